// File: rtl/poly_mult_pkg.sv
// poly_mult_pkg
//   Shared definitions for the poly_mult host controller: key-map base
//   functions derived from the block parameters, the host-region and FSM
//   state enums, and the bit positions inside the CTRL status word.
//   No ports (package).
package poly_mult_pkg;

  // Host FSM: idle, two-cycle read pipeline, core owns the memories.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_CAP  = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  // Region a host key falls into.
  typedef enum logic [2:0] {
    REG_POS  = 3'd0,
    REG_VEC  = 3'd1,
    REG_RES  = 3'd2,
    REG_CTRL = 3'd3,
    REG_NONE = 3'd4
  } region_e;

  // Bit positions inside the CTRL status word.
  localparam int STAT_RUNNING = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_W       = 3;

  // First key of the vector region (positions occupy [0, weight)).
  function automatic int vec_base(input int weight);
    return weight;
  endfunction

  // First key of the read-only result region.
  function automatic int res_base(input int weight, input int ramsize);
    return weight + ramsize;
  endfunction

  // One past the last result key.
  function automatic int res_end(input int weight, input int ramsize);
    return weight + 2 * ramsize;
  endfunction

  // The control key is the all-ones key.
  function automatic int ctrl_key(input int key_w);
    return (1 << key_w) - 1;
  endfunction

endpackage

// File: rtl/poly_mult_host_ctrl_if.sv
// poly_mult_host_ctrl_if
//   Keyed host bus of the poly_mult host controller.
//   load_i  : request strobe, one cycle per request
//   we_i    : 1 = write, 0 = read
//   key_i   : host key (KEY_W)
//   data_i  : write data (DATA_W)
//   data_o  : read data, zero-extended (DATA_W)
//   ack_o   : one-cycle acknowledge
//   busy_o  : request in flight or core running
interface poly_mult_host_ctrl_if #(
  parameter int KEY_W  = 12,
  parameter int DATA_W = 128
) ();

  logic              load_i;
  logic              we_i;
  logic [KEY_W-1:0]  key_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              ack_o;
  logic              busy_o;

  modport master (
    output load_i, we_i, key_i, data_i,
    input  data_o, ack_o, busy_o
  );

  modport slave (
    input  load_i, we_i, key_i, data_i,
    output data_o, ack_o, busy_o
  );

endinterface

// File: rtl/mem_dual.sv
// mem_dual
//   Dual-port synchronous RAM: port 0 read/write, port 1 read-only.
//   Reads are registered (q valid the cycle after the address).
//   Out-of-range addresses read 0 and never write.
//   clk            : clock
//   we_0           : port 0 write enable
//   addr_0, din_0  : port 0 address / write data
//   q_0            : port 0 read data
//   addr_1, q_1    : port 1 address / read data
module mem_dual #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_0,
  input  logic [AW-1:0]    addr_0,
  input  logic [WIDTH-1:0] din_0,
  output logic [WIDTH-1:0] q_0,
  input  logic [AW-1:0]    addr_1,
  output logic [WIDTH-1:0] q_1
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write and registered reads (read-before-write on port 0).
  always_ff @(posedge clk) begin
    if (we_0 && (32'(addr_0) < 32'(DEPTH))) begin
      mem_r[addr_0] <= din_0;
    end
    q_0 <= (32'(addr_0) < 32'(DEPTH)) ? mem_r[addr_0] : '0;
    q_1 <= (32'(addr_1) < 32'(DEPTH)) ? mem_r[addr_1] : '0;
  end

endmodule

// File: rtl/poly_mult_key_decode.sv
// poly_mult_key_decode
//   Combinational host-key decoder.
//   key    : host key
//   region : POS / VEC / RES / CTRL / NONE
//   offset : key minus the base of its region (0 for CTRL / NONE)
//   hit    : key is mapped
module poly_mult_key_decode
  import poly_mult_pkg::*;
#(
  parameter int WEIGHT     = 2,
  parameter int RAMSIZE    = 554,
  parameter int KEY_W      = 12,
  parameter int ADDR_WIDTH = $clog2(RAMSIZE)
) (
  input  logic [KEY_W-1:0]      key,
  output region_e               region,
  output logic [ADDR_WIDTH-1:0] offset,
  output logic                  hit
);

  localparam logic [KEY_W-1:0] VEC_B  = KEY_W'(vec_base(WEIGHT));
  localparam logic [KEY_W-1:0] RES_B  = KEY_W'(res_base(WEIGHT, RAMSIZE));
  localparam logic [KEY_W-1:0] RES_E  = KEY_W'(res_end(WEIGHT, RAMSIZE));
  localparam logic [KEY_W-1:0] CTRL_K = KEY_W'(ctrl_key(KEY_W));

  // Region lookup; CTRL is checked first so it wins over any overlap.
  always_comb begin
    region = REG_NONE;
    offset = '0;
    hit    = 1'b0;
    if (key == CTRL_K) begin
      region = REG_CTRL;
      hit    = 1'b1;
    end else if (key < VEC_B) begin
      region = REG_POS;
      offset = ADDR_WIDTH'(key);
      hit    = 1'b1;
    end else if (key < RES_B) begin
      region = REG_VEC;
      offset = ADDR_WIDTH'(key - VEC_B);
      hit    = 1'b1;
    end else if (key < RES_E) begin
      region = REG_RES;
      offset = ADDR_WIDTH'(key - RES_B);
      hit    = 1'b1;
    end else begin
      region = REG_NONE;
    end
  end

endmodule

// File: rtl/poly_mult_host_ctrl.sv
// poly_mult_host_ctrl
//   Host-side controller for the sparse polynomial multiplier. Owns the
//   position RAM and the vector RAM, decodes the keyed host bus into
//   writes, reads, result readback and start, and hands the memories to
//   the core while it runs.
//   clk, rst           : clock, synchronous active-high reset
//   host               : keyed host bus (slave side)
//   core_start         : one-cycle start pulse to the core
//   core_loc_addr/in   : position RAM read by the core
//   core_addr_0/1      : vector RAM addresses from the core
//   core_word_0/1      : vector words to the core, zero-masked
//   core_valid         : core completion
//   core_rd_dout       : result read enable (same cycle as the host read)
//   core_addr_result   : result read address
//   core_dout          : result word, valid one cycle after core_rd_dout
module poly_mult_host_ctrl
  import poly_mult_pkg::*;
#(
  parameter int WEIGHT     = 2,
  parameter int LOGW       = 16,
  parameter int RAMWIDTH   = 32,
  parameter int RAMSIZE    = 554,
  parameter int ZERO_FROM  = RAMSIZE / 2,
  parameter int KEY_W      = 12,
  parameter int DATA_W     = 128,
  parameter int ADDR_WIDTH = $clog2(RAMSIZE),
  parameter int LOC_W      = (WEIGHT > 1) ? $clog2(WEIGHT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  poly_mult_host_ctrl_if.slave  host,
  output logic                  core_start,
  input  logic [LOC_W-1:0]      core_loc_addr,
  output logic [LOGW-1:0]       core_loc_in,
  input  logic [ADDR_WIDTH-1:0] core_addr_0,
  input  logic [ADDR_WIDTH-1:0] core_addr_1,
  output logic [RAMWIDTH-1:0]   core_word_0,
  output logic [RAMWIDTH-1:0]   core_word_1,
  input  logic                  core_valid,
  output logic                  core_rd_dout,
  output logic [ADDR_WIDTH-1:0] core_addr_result,
  input  logic [RAMWIDTH-1:0]   core_dout
);

  state_e                state_r, state_s;
  region_e               dec_region_s, rd_region_r;
  logic [ADDR_WIDTH-1:0] dec_offset_s;
  logic                  dec_hit_s;

  logic                  idle_s, run_s;
  logic                  req_s, accept_s, reject_s, wr_ok_s, rd_ok_s;
  logic                  start_s, clr_err_s, pos_we_s, vec_we_s, res_rd_s;

  logic [DATA_W-1:0]     data_o_r, rd_data_s;
  logic                  ack_r, busy_r, start_r, done_r, err_r;
  logic [STAT_W-1:0]     status_s;

  logic [LOGW-1:0]       pos_q0_s, pos_q1_s;
  logic [RAMWIDTH-1:0]   vec_q0_s, vec_q1_s;
  logic [ADDR_WIDTH-1:0] vec_addr0_s;
  logic [ADDR_WIDTH-1:0] core_addr_0_r, core_addr_1_r;

  poly_mult_key_decode #(
    .WEIGHT     (WEIGHT),
    .RAMSIZE    (RAMSIZE),
    .KEY_W      (KEY_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .key    (host.key_i),
    .region (dec_region_s),
    .offset (dec_offset_s),
    .hit    (dec_hit_s)
  );

  assign idle_s = (state_r == ST_IDLE);
  assign run_s  = (state_r == ST_RUN);
  assign req_s  = host.load_i && !rst;

  // Only an idle controller takes requests; writes to RES or unmapped keys
  // and anything arriving while busy are acknowledged but dropped.
  assign accept_s  = req_s && idle_s;
  assign wr_ok_s   = accept_s && host.we_i && dec_hit_s && (dec_region_s != REG_RES);
  assign rd_ok_s   = accept_s && !host.we_i;
  assign reject_s  = req_s && (!idle_s || (host.we_i && !wr_ok_s));
  assign start_s   = wr_ok_s && (dec_region_s == REG_CTRL) && host.data_i[0];
  assign clr_err_s = wr_ok_s && (dec_region_s == REG_CTRL) && host.data_i[1];
  assign pos_we_s  = wr_ok_s && (dec_region_s == REG_POS);
  assign vec_we_s  = wr_ok_s && (dec_region_s == REG_VEC);
  assign res_rd_s  = rd_ok_s && (dec_region_s == REG_RES);

  // The result read is issued in the request cycle so core_dout lands in
  // the same cycle as the RAM q of a normal read.
  assign core_rd_dout     = res_rd_s;
  assign core_addr_result = res_rd_s ? dec_offset_s : '0;

  // Vector port 0 follows the core while it runs, the host otherwise.
  assign vec_addr0_s = run_s ? core_addr_0 : dec_offset_s;

  mem_dual #(
    .WIDTH (LOGW),
    .DEPTH (WEIGHT),
    .AW    (LOC_W)
  ) u_pos_ram (
    .clk    (clk),
    .we_0   (pos_we_s),
    .addr_0 (LOC_W'(dec_offset_s)),
    .din_0  (host.data_i[LOGW-1:0]),
    .q_0    (pos_q0_s),
    .addr_1 (core_loc_addr),
    .q_1    (pos_q1_s)
  );

  mem_dual #(
    .WIDTH (RAMWIDTH),
    .DEPTH (RAMSIZE),
    .AW    (ADDR_WIDTH)
  ) u_vec_ram (
    .clk    (clk),
    .we_0   (vec_we_s),
    .addr_0 (vec_addr0_s),
    .din_0  (host.data_i[RAMWIDTH-1:0]),
    .q_0    (vec_q0_s),
    .addr_1 (core_addr_1),
    .q_1    (vec_q1_s)
  );

  // Core address pipeline, aligned with the registered RAM read data.
  always_ff @(posedge clk) begin
    core_addr_0_r <= core_addr_0;
    core_addr_1_r <= core_addr_1;
  end

  assign core_loc_in = pos_q1_s;
  assign core_word_0 = ((32'(core_addr_0_r) >= 32'(ZERO_FROM)) ||
                        (32'(core_addr_0_r) >= 32'(RAMSIZE))) ? '0 : vec_q0_s;
  assign core_word_1 = ((32'(core_addr_1_r) >= 32'(ZERO_FROM)) ||
                        (32'(core_addr_1_r) >= 32'(RAMSIZE))) ? '0 : vec_q1_s;

  // Status word assembly.
  always_comb begin
    status_s               = '0;
    status_s[STAT_RUNNING] = run_s;
    status_s[STAT_DONE]    = done_r;
    status_s[STAT_ERR]     = err_r;
  end

  // Read-data source for the region latched at read acceptance.
  always_comb begin
    rd_data_s = '0;
    case (rd_region_r)
      REG_POS:  rd_data_s = DATA_W'(pos_q0_s);
      REG_VEC:  rd_data_s = DATA_W'(vec_q0_s);
      REG_RES:  rd_data_s = DATA_W'(core_dout);
      REG_CTRL: rd_data_s = DATA_W'(status_s);
      default:  rd_data_s = '0;
    endcase
  end

  // FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rd_ok_s) begin
          state_s = ST_RD_WAIT;
        end else if (start_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: state_s = ST_RD_CAP;
      ST_RD_CAP:  state_s = ST_IDLE;
      ST_RUN: begin
        if (core_valid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, host outputs, start pulse and sticky status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rd_region_r <= REG_NONE;
      data_o_r    <= '0;
      ack_r       <= 1'b0;
      busy_r      <= 1'b0;
      start_r     <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      start_r <= start_s;
      // Writes and rejects ack next cycle; reads ack once data is captured.
      ack_r   <= wr_ok_s || reject_s || (state_r == ST_RD_WAIT);
      if (rd_ok_s) begin
        rd_region_r <= dec_region_s;
      end
      if (state_r == ST_RD_WAIT) begin
        data_o_r <= rd_data_s;
      end
      if (start_s) begin
        done_r <= 1'b0;
      end else if (run_s && core_valid) begin
        done_r <= 1'b1;
      end
      if (reject_s) begin
        err_r <= 1'b1;
      end else if (clr_err_s) begin
        err_r <= 1'b0;
      end
    end
  end

  assign host.data_o  = data_o_r;
  assign host.ack_o   = ack_r;
  assign host.busy_o  = busy_r;
  assign core_start   = start_r;

endmodule

// File: tb/tb_poly_mult_host_ctrl.sv
// tb_poly_mult_host_ctrl
//   Directed bench for poly_mult_host_ctrl with default parameters
//   (WEIGHT=2, RAMSIZE=554, ZERO_FROM=277, KEY_W=12, DATA_W=128).
module tb_poly_mult_host_ctrl;

  localparam logic [11:0] K_POS1   = 12'd1;
  localparam logic [11:0] K_VEC5   = 12'd7;     // WEIGHT + 5
  localparam logic [11:0] K_VEC_ZF = 12'd279;   // WEIGHT + ZERO_FROM
  localparam logic [11:0] K_RES3   = 12'd559;   // WEIGHT + RAMSIZE + 3
  localparam logic [11:0] K_UNMAP  = 12'd2000;
  localparam logic [11:0] K_CTRL   = 12'hFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_start;
  logic [0:0]  core_loc_addr;
  logic [15:0] core_loc_in;
  logic [9:0]  core_addr_0, core_addr_1;
  logic [31:0] core_word_0, core_word_1;
  logic        core_valid;
  logic        core_rd_dout;
  logic [9:0]  core_addr_result;
  logic [31:0] core_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  poly_mult_host_ctrl_if #(.KEY_W(12), .DATA_W(128)) hif ();

  poly_mult_host_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .host             (hif),
    .core_start       (core_start),
    .core_loc_addr    (core_loc_addr),
    .core_loc_in      (core_loc_in),
    .core_addr_0      (core_addr_0),
    .core_addr_1      (core_addr_1),
    .core_word_0      (core_word_0),
    .core_word_1      (core_word_1),
    .core_valid       (core_valid),
    .core_rd_dout     (core_rd_dout),
    .core_addr_result (core_addr_result),
    .core_dout        (core_dout)
  );

  // Result memory stand-in: answers a read one cycle after core_rd_dout.
  always @(posedge clk) core_dout <= core_rd_dout ? 32'hA5A5A5A5 : 32'h0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; returns 1ns into cycle T+1.
  task automatic issue(input logic we, input logic [11:0] key, input logic [127:0] data);
    @(negedge clk);
    hif.load_i = 1'b1;
    hif.we_i   = we;
    hif.key_i  = key;
    hif.data_i = data;
    next_cycle();
    hif.load_i = 1'b0;
  endtask

  // Read and check at T+2, then let the FSM return to idle.
  task automatic host_read(input string tag, input logic [11:0] key, input logic [127:0] exp);
    issue(1'b0, key, 128'd0);
    next_cycle();
    check_eq({tag, "_ack"}, 128'(hif.ack_o), 128'd1);
    check_eq(tag, hif.data_o, exp);
    next_cycle();
  endtask

  initial begin
    rst           = 1'b1;
    hif.load_i    = 1'b0;
    hif.we_i      = 1'b0;
    hif.key_i     = 12'd0;
    hif.data_i    = 128'd0;
    core_loc_addr = 1'b0;
    core_addr_0   = 10'd0;
    core_addr_1   = 10'd0;
    core_valid    = 1'b0;

    next_cycle();
    next_cycle();
    check_eq("rst_data_o", hif.data_o, 128'd0);
    check_eq("rst_ack", 128'(hif.ack_o), 128'd0);
    check_eq("rst_busy", 128'(hif.busy_o), 128'd0);
    check_eq("rst_start", 128'(core_start), 128'd0);
    check_eq("rst_rd_dout", 128'(core_rd_dout), 128'd0);
    check_eq("rst_addr_res", 128'(core_addr_result), 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // POS write: ack in T+1, not busy, single-cycle ack.
    issue(1'b1, K_POS1, 128'h1234);
    check_eq("wr_pos_ack", 128'(hif.ack_o), 128'd1);
    check_eq("wr_pos_busy", 128'(hif.busy_o), 128'd0);
    next_cycle();
    check_eq("wr_pos_ack_drop", 128'(hif.ack_o), 128'd0);

    // POS read with full timing.
    issue(1'b0, K_POS1, 128'd0);
    check_eq("rd_t1_busy", 128'(hif.busy_o), 128'd1);
    check_eq("rd_t1_ack", 128'(hif.ack_o), 128'd0);
    next_cycle();
    check_eq("rd_t2_ack", 128'(hif.ack_o), 128'd1);
    check_eq("rd_t2_data", hif.data_o, 128'h1234);
    check_eq("rd_t2_busy", 128'(hif.busy_o), 128'd1);
    next_cycle();
    check_eq("rd_t3_busy", 128'(hif.busy_o), 128'd0);
    host_read("ctrl_clean", K_CTRL, 128'd0);

    // Back-to-back VEC writes, unmapped read, VEC readback.
    issue(1'b1, K_VEC5, 128'hDEADBEEF);
    issue(1'b1, K_VEC_ZF, 128'h11111111);
    host_read("rd_unmapped", K_UNMAP, 128'd0);
    host_read("rd_vec5", K_VEC5, 128'hDEADBEEF);
    host_read("rd_vec_zf", K_VEC_ZF, 128'h11111111);
    host_read("rd_vec5_again", K_VEC5, 128'hDEADBEEF);

    // Start the core.
    issue(1'b1, K_CTRL, 128'h1);
    check_eq("start_pulse", 128'(core_start), 128'd1);
    check_eq("start_busy", 128'(hif.busy_o), 128'd1);
    check_eq("start_ack", 128'(hif.ack_o), 128'd1);
    next_cycle();
    check_eq("start_pulse_drop", 128'(core_start), 128'd0);
    check_eq("run_busy", 128'(hif.busy_o), 128'd1);

    // Core-side reads: masking at ZERO_FROM, position readout.
    @(negedge clk);
    core_addr_0   = 10'd5;
    core_addr_1   = 10'd277;
    core_loc_addr = 1'b1;
    next_cycle();
    check_eq("core_word0_a5", 128'(core_word_0), 128'hDEADBEEF);
    check_eq("core_word1_zf", 128'(core_word_1), 128'd0);
    check_eq("core_loc_in", 128'(core_loc_in), 128'h1234);
    @(negedge clk);
    core_addr_0 = 10'd277;
    core_addr_1 = 10'd5;
    next_cycle();
    check_eq("core_word0_zf", 128'(core_word_0), 128'd0);
    check_eq("core_word1_a5", 128'(core_word_1), 128'hDEADBEEF);

    // Write during RUN is acked but dropped.
    issue(1'b1, K_VEC5, 128'h0BADF00D);
    check_eq("run_wr_ack", 128'(hif.ack_o), 128'd1);
    check_eq("run_wr_busy", 128'(hif.busy_o), 128'd1);

    // Completion.
    @(negedge clk);
    core_valid = 1'b1;
    next_cycle();
    core_valid = 1'b0;
    check_eq("done_busy", 128'(hif.busy_o), 128'd0);
    check_eq("done_data_keep", hif.data_o, 128'hDEADBEEF);
    host_read("ctrl_done_err", K_CTRL, 128'h6);
    host_read("vec5_unchanged", K_VEC5, 128'hDEADBEEF);

    // Clear err; write to RES sets it again.
    issue(1'b1, K_CTRL, 128'h2);
    host_read("ctrl_err_clr", K_CTRL, 128'h2);
    issue(1'b1, K_RES3, 128'h5);
    host_read("ctrl_res_wr_err", K_CTRL, 128'h6);
    issue(1'b1, K_CTRL, 128'h2);

    // Result readback at offset 3.
    @(negedge clk);
    hif.load_i = 1'b1;
    hif.we_i   = 1'b0;
    hif.key_i  = K_RES3;
    #1;
    check_eq("res_rd_en", 128'(core_rd_dout), 128'd1);
    check_eq("res_addr", 128'(core_addr_result), 128'd3);
    next_cycle();
    hif.load_i = 1'b0;
    next_cycle();
    check_eq("res_ack", 128'(hif.ack_o), 128'd1);
    check_eq("res_data", hif.data_o, 128'hA5A5A5A5);
    next_cycle();

    // Reset mid-RUN abandons the run; a late core_valid is ignored.
    issue(1'b1, K_CTRL, 128'h1);
    next_cycle();
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    check_eq("mid_rst_busy", 128'(hif.busy_o), 128'd0);
    check_eq("mid_rst_ack", 128'(hif.ack_o), 128'd0);
    check_eq("mid_rst_start", 128'(core_start), 128'd0);
    check_eq("mid_rst_data", hif.data_o, 128'd0);
    @(negedge clk);
    rst        = 1'b0;
    core_valid = 1'b1;
    next_cycle();
    core_valid = 1'b0;
    check_eq("late_valid_busy", 128'(hif.busy_o), 128'd0);
    host_read("late_valid_ctrl", K_CTRL, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_mult_host_ctrl.md
# poly_mult_host_ctrl

Parametrised host-side controller for the sparse polynomial multiplier, and the successor to the fixed-map top-level loader. It owns the position RAM and the random-vector RAM, and decodes a keyed host bus into writes, reads, result readback and a start command. The address map is derived from parameters rather than hard-coded, and writes and reads are separated by an explicit write enable. A four-state FSM arbitrates memory ownership between the host and the external `poly_mult` core, with a fixed-latency acknowledge and a sticky status word.

## Interface
Parameters:
- WEIGHT, 2: number of position entries.
- LOGW, 16: width of a position entry.
- RAMWIDTH, 32: vector/result word width.
- RAMSIZE, 554: vector RAM depth in words.
- ZERO_FROM, RAMSIZE/2: core-side vector reads at addresses at or above this value return 0.
- KEY_W, 12: host key width.
- DATA_W, 128: host data width.
- ADDR_WIDTH, CLOG2(RAMSIZE): vector/result address width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- load_i  in  1  host request strobe, one cycle per request.
- we_i  in  1  1 = write, 0 = read; sampled with load_i.
- key_i  in  KEY_W  host key.
- data_i  in  DATA_W  write data.
- data_o  out  DATA_W  read data, zero-extended.
- ack_o  out  1  one-cycle request acknowledge.
- busy_o  out  1  request in flight or core running.
- core_start  out  1  one-cycle start pulse to the core.
- core_loc_addr  in  CLOG2(WEIGHT)  position address from the core.
- core_loc_in  out  LOGW  position data to the core.
- core_addr_0, core_addr_1  in  ADDR_WIDTH  vector addresses from the core.
- core_word_0, core_word_1  out  RAMWIDTH  vector words to the core, zero-masked.
- core_valid  in  1  core completion.
- core_rd_dout  out  1  result read enable.
- core_addr_result  out  ADDR_WIDTH  result read address.
- core_dout  in  RAMWIDTH  result word, valid one cycle after core_rd_dout.

## Operation
- Key map:
  - POS: [0, WEIGHT).
  - VEC: [WEIGHT, WEIGHT+RAMSIZE).
  - RES: [WEIGHT+RAMSIZE, WEIGHT+2·RAMSIZE), read-only.
  - CTRL: 2^KEY_W−1.
  - Any other key is unmapped.
- Writes:
  - POS stores data_i[LOGW-1:0].
  - VEC stores data_i[RAMWIDTH-1:0].
  - CTRL with data_i[0]=1 issues start.
  - CTRL with data_i[1]=1 clears err.
- Reads:
  - POS and VEC return RAM contents.
  - RES drives core_rd_dout and core_addr_result = key−RES base, and returns core_dout.
  - CTRL returns {…0, err, done, running} in bits [2:0].
  - Unmapped keys return 0.
- FSM states: IDLE, RD_WAIT, RD_CAP, RUN.
  - IDLE → RD_WAIT on a read.
  - RD_WAIT → RD_CAP (RAM q or core_dout is valid).
  - RD_CAP → IDLE.
  - IDLE → RUN on start.
  - RUN → IDLE on core_valid.
- Memory ownership:
  - In IDLE/RD_*, the host drives RAM port addresses.
  - In RUN, core_loc_addr, core_addr_0 and core_addr_1 drive them.
- Masking: core_word_x = 0 when the registered core_addr_x ≥ ZERO_FROM or ≥ RAMSIZE.
- Status bits:
  - done: sticky; set on core_valid, cleared by start.
  - err: sticky; set by any write or start issued during RUN or RD_*, any write to RES or unmapped keys, and any load_i while busy_o=1.
- Every rejected request is still acknowledged and has no other effect.
- Reset:
  - data_o=0, ack_o=0, busy_o=0, core_start=0, core_rd_dout=0, core_addr_result=0, state=IDLE, done=0, err=0.
  - RAM contents are not cleared.
  - Reset during RUN abandons the run; a later core_valid is ignored unless a new start has been issued.

## Timing
- Write: load_i in cycle T commits to RAM at the T clock edge; ack_o is high in T+1; busy_o stays 0.
- Read: load_i in cycle T; RAM q or core_dout is valid in T+1; data_o is updated and ack_o is high in T+2; busy_o is high in T+1..T+2.
- Start: core_start is high exactly in T+1 and busy_o is high from T+1. On core_valid in cycle V: done=1 and busy_o=0 from V+1; data_o is unchanged.
- Simultaneous events:
  - load_i arriving in the same cycle as core_valid is rejected (busy).
  - core_valid outside RUN is ignored.
- Back-to-back writes are accepted every cycle. Reads need 3 cycles per request.

## Structure
- Package poly_mult_pkg holds:
  - key-map base functions (POS/VEC/RES/CTRL derived from WEIGHT, RAMSIZE, KEY_W);
  - the FSM state enum;
  - status bit indices.
- Sub-module poly_mult_key_decode is combinational: key_i → {region, offset, hit}.
- Both RAMs are existing mem_dual instances.

## Test plan
- Write POS key 1 with 0x1234, then read key 1 → ack_o in T+1 for the write; data_o=0x1234 in T+2; err=0.
- Write VEC key WEIGHT+5 with 0xDEADBEEF; start the core; the core reads addr 5 → core_word_0=0xDEADBEEF. The core reads addr ZERO_FROM → core_word_0=0.
- Write CTRL 0x1 → core_start high for one cycle; busy_o=1 until core_valid; CTRL read then returns 0b010.
- Write VEC during RUN → ack_o is pulsed, RAM is unchanged, CTRL read after completion returns 0b110. Write CTRL 0x2 → err clears.
- Read RES key offset 3 with core_dout=0xA5A5A5A5 → core_addr_result=3; data_o=0xA5A5A5A5 in T+2.
- Assert rst mid-RUN → all outputs return to reset values next cycle; a subsequent core_valid leaves done=0.
